// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle chunked ripple adder/subtractor with start/busy/done handshake
//
// Purpose: adds or subtracts two WIDTH-bit operands CHUNK bits per clock. Each
// compute cycle ripples one chunk through a chain of full-adder cells, and a
// carry register links the chunks.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request an operation (sampled only in IDLE)
//   a, b     WIDTH-bit operands (captured on the accepted start)
//   cin      carry-in (add) / borrow-in (sub), captured on the accepted start
//   sub      0: a+b+cin, 1: a-b-cin, captured on the accepted start
//   busy     high while chunks are being computed
//   done     one-cycle pulse when sum/carry/overflow become valid
//   sum      registered WIDTH-bit result (modulo 2^WIDTH)
//   carry    carry out of the MSB (in sub mode 1 means no borrow)
//   overflow two's-complement signed overflow
//
// WIDTH must be a positive multiple of CHUNK.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  // Keep the index register at least one bit wide so N=1 still elaborates.
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic             c_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // Chunk datapath
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_ripple;
  logic             c_msb_in;  // carry into the top bit of the chunk
  logic             c_out;
  logic [WIDTH-1:0] res_d;
  int               base;

  always_comb begin
    base     = int'(k_q) * CHUNK;
    a_chunk  = a_q[base +: CHUNK];
    b_chunk  = b_q[base +: CHUNK];
    s_chunk  = '0;
    c_ripple = c_q;
    c_msb_in = c_q;
    for (int j = 0; j < CHUNK; j++) begin
      c_msb_in   = c_ripple;
      s_chunk[j] = a_chunk[j] ^ b_chunk[j] ^ c_ripple;
      c_ripple   = (a_chunk[j] & b_chunk[j]) | (c_ripple & (a_chunk[j] ^ b_chunk[j]));
    end
    c_out = c_ripple;
    res_d = res_q;
    res_d[base +: CHUNK] = s_chunk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // a - b - cin == a + ~b + (1 - cin)
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= cin ^ sub;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          res_q <= res_d;
          c_q   <= c_out;
          if (k_q == K_LAST) begin
            sum_q   <= res_d;
            carry_q <= c_out;
            ovf_q   <= c_msb_in ^ c_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;

  logic       busy1, done1, carry1, ovf1;
  logic       busy4, done4, carry4, ovf4;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum1, sum4, sum8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1));

  serial_addsub #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(ovf4));

  serial_addsub #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives operands, raises the selected start for one accepting edge.
  task automatic start_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb);
    a = av; b = bv; cin = ci; sub = sb;
    if (w == 1) start1 = 1'b1;
    else if (w == 4) start4 = 1'b1;
    else start8 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
  endtask

  function automatic logic sel_done(input int w);
    return (w == 1) ? done1 : (w == 4) ? done4 : done8;
  endfunction

  function automatic logic sel_busy(input int w);
    return (w == 1) ? busy1 : (w == 4) ? busy4 : busy8;
  endfunction

  // Returns edges waited until done is seen (-1 on timeout) and busy cycles seen.
  task automatic wait_done(input int w, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!sel_done(w)) begin
      if (lat > 40) begin
        lat = -1;
        return;
      end
      if (sel_busy(w)) bcnt++;
      tick();
      lat++;
    end
  endtask

  // Independent reference: returns {overflow, carry, sum}.
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic sb);
    logic [7:0] bb;
    logic [8:0] t;
    logic       ov;
    bb = sb ? ~bv : bv;
    t  = {1'b0, av} + {1'b0, bb} + {8'd0, ci ^ sb};
    ov = (av[7] == bb[7]) && (t[7] != av[7]);
    return {ov, t};
  endfunction

  int lat, bcnt, dcnt;
  logic [7:0] va, vb;
  logic       vc, vs;
  logic [9:0] exp_v;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_sum", sum1, 0);
    check("rst_carry", carry1, 0);
    check("rst_ovf", ovf1, 0);
    rst = 1'b0;
    tick();

    // 3C + 5A
    start_op(1, 8'h3C, 8'h5A, 1'b0, 1'b0);
    wait_done(1, lat, bcnt);
    check("add_lat", lat, 8);
    check("add_busycnt", bcnt, 8);
    check("add_sum", sum1, 8'h96);
    check("add_carry", carry1, 0);
    check("add_ovf", ovf1, 1);
    check("add_busy_in_done", busy1, 0);
    tick();
    check("add_done_pulse", done1, 0);
    check("add_sum_hold", sum1, 8'h96);

    // 10 - 20
    start_op(1, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(1, lat, bcnt);
    check("sub1_sum", sum1, 8'hF0);
    check("sub1_carry", carry1, 0);
    check("sub1_ovf", ovf1, 0);
    tick();

    // 80 - 01
    start_op(1, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(1, lat, bcnt);
    check("sub2_sum", sum1, 8'h7F);
    check("sub2_carry", carry1, 1);
    check("sub2_ovf", ovf1, 1);
    tick();

    // FF + 01, then FF + 00 + cin
    start_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(1, lat, bcnt);
    check("wrap1_sum", sum1, 8'h00);
    check("wrap1_carry", carry1, 1);
    check("wrap1_ovf", ovf1, 0);
    tick();
    start_op(1, 8'hFF, 8'h00, 1'b1, 1'b0);
    wait_done(1, lat, bcnt);
    check("wrap2_sum", sum1, 8'h00);
    check("wrap2_carry", carry1, 1);
    check("wrap2_ovf", ovf1, 0);
    tick();

    // Handshake: start pulses during RUN cycles 2 and 5 are ignored
    start_op(1, 8'h3C, 8'h5A, 1'b0, 1'b0);      // now in RUN cycle 1
    tick();                                      // RUN cycle 2
    a = 8'h11; b = 8'h22; sub = 1'b1; start1 = 1'b1;
    tick(); start1 = 1'b0;                       // RUN cycle 3
    tick(); tick();                              // RUN cycle 5
    a = 8'hAA; b = 8'h55; cin = 1'b1; start1 = 1'b1;
    tick(); start1 = 1'b0;                       // RUN cycle 6
    wait_done(1, lat, bcnt);
    check("hs_lat_rest", lat, 3);
    check("hs_sum", sum1, 8'h96);
    check("hs_ovf", ovf1, 1);
    // start held through DONE is accepted only in the following IDLE cycle
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    tick();
    check("hs_idle_done", done1, 0);
    check("hs_idle_busy", busy1, 0);
    tick();
    check("hs_accept_busy", busy1, 1);
    start1 = 1'b0;
    wait_done(1, lat, bcnt);
    check("hs_second_lat", lat, 8);
    check("hs_second_sum", sum1, 8'h03);
    tick();

    // Asynchronous reset mid-operation (RUN cycle 4), no done afterwards
    start_op(1, 8'hF0, 8'h0F, 1'b1, 1'b0);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy1, 0);
    check("arst_sum", sum1, 0);
    check("arst_done", done1, 0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done1) dcnt++;
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done1 || busy1) dcnt++;
    end
    check("arst_no_done", dcnt, 0);
    start_op(1, 8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(1, lat, bcnt);
    check("arst_fresh_lat", lat, 8);
    check("arst_fresh_sum", sum1, 8'h02);
    check("arst_fresh_carry", carry1, 0);
    tick();

    // Directed checks on the wider-chunk instances
    start_op(4, 8'h3C, 8'h5A, 1'b0, 1'b0);
    wait_done(4, lat, bcnt);
    check("c4_lat", lat, 2);
    check("c4_sum", sum4, 8'h96);
    check("c4_ovf", ovf4, 1);
    tick();
    start_op(8, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(8, lat, bcnt);
    check("c8_lat", lat, 1);
    check("c8_sum", sum8, 8'h7F);
    check("c8_carry", carry8, 1);
    check("c8_ovf", ovf8, 1);
    tick();

    // Spread of operand patterns across both modes on CHUNK=4 and CHUNK=8
    for (int i = 0; i < 96; i++) begin
      va = 8'(i * 37 + 5);
      vb = 8'(i * 91 + 13);
      vc = i[0];
      vs = i[1];
      exp_v = model(va, vb, vc, vs);
      start_op(4, va, vb, vc, vs);
      wait_done(4, lat, bcnt);
      check("sw4_lat", lat, 2);
      check("sw4_res", {ovf4, carry4, sum4}, exp_v);
      tick();
      start_op(8, va, vb, vc, vs);
      wait_done(8, lat, bcnt);
      check("sw8_lat", lat, 1);
      check("sw8_res", {ovf8, carry8, sum8}, exp_v);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
